// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter between
// the instruction-fetch and data-memory requesters.
package memory_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      BUSY_FETCH = 2'b01,
      BUSY_DATA  = 2'b10
   } arb_state_t;

   localparam logic OWNER_FETCH = 1'b0;
   localparam logic OWNER_DATA  = 1'b1;

   // Width of a counter that must hold 0..limit; a zero limit still needs one bit.
   function automatic int unsigned count_width(input int unsigned limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/fetch_data_grant.sv
// Data-priority grant decision with a starvation bound for fetch: after
// STARVE_LIMIT consecutive data grants while fetch waits, fetch wins.
module fetch_data_grant
   import memory_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic arbitrate,
   input  logic accept,
   input  logic fetch_read,
   input  logic data_request,
   output logic grant_fetch,
   output logic grant_data
);

   localparam int unsigned CW = count_width(STARVE_LIMIT);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_count;
   logic          fetch_turn;

   assign fetch_turn = (starve_count == LIMIT);

   // NOTE: every output gets a default before any branch, so no latch is inferred.
   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      if (arbitrate) begin
         if (fetch_read && (!data_request || fetch_turn)) begin
            grant_fetch = 1'b1;
         end else if (data_request) begin
            grant_data = 1'b1;
         end
      end
   end

   // A grant only counts once the memory actually takes the command.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_count <= '0;
      end else if (accept) begin
         if (grant_fetch) begin
            starve_count <= '0;
         end else if (grant_data && fetch_read && !fetch_turn) begin
            starve_count <= starve_count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters with one
// transaction in flight; drops fetch responses flushed by the control unit.
module memory_port_arbiter
   import memory_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDRESS_BITS = 20,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    fetch_read,
   input  logic [ADDRESS_BITS-1:0] fetch_address,
   input  logic                    fetch_flush,
   output logic                    fetch_ready,
   output logic                    fetch_valid,
   output logic [DATA_WIDTH-1:0]   fetch_data,
   output logic [ADDRESS_BITS-1:0] fetch_address_out,
   input  logic                    data_read,
   input  logic                    data_write,
   input  logic [ADDRESS_BITS-1:0] data_address,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    data_ready,
   output logic                    data_valid,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [ADDRESS_BITS-1:0] data_address_out,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ready,
   input  logic                    mem_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   arb_state_t              state, state_next;
   logic [ADDRESS_BITS-1:0] address_q;
   logic                    drop_q, drop_next;
   logic                    arbitrate, grant_fetch, grant_data, winner;
   logic                    deliver_fetch, deliver_data;

   // Gating with reset keeps every command and ready output low while reset is held.
   assign arbitrate = reset && (state == IDLE);
   assign winner    = grant_data ? OWNER_DATA : OWNER_FETCH;

   fetch_data_grant #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant (
      .clock        (clock),
      .reset        (reset),
      .arbitrate    (arbitrate),
      .accept       (mem_ready),
      .fetch_read   (fetch_read),
      .data_request (data_read || data_write),
      .grant_fetch  (grant_fetch),
      .grant_data   (grant_data)
   );

   always_comb begin
      state_next  = state;
      drop_next   = drop_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      fetch_ready = 1'b0;
      data_ready  = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_fetch || grant_data) begin
               if (winner == OWNER_DATA) begin
                  mem_address = data_address;
                  data_ready  = mem_ready;
                  // A store wins over a simultaneous load and finishes on acceptance.
                  if (data_write) begin
                     mem_write = 1'b1;
                     mem_wdata = data_in;
                  end else begin
                     mem_read = 1'b1;
                     if (mem_ready) state_next = BUSY_DATA;
                  end
               end else begin
                  mem_address = fetch_address;
                  mem_read    = 1'b1;
                  fetch_ready = mem_ready;
                  if (mem_ready) begin
                     state_next = BUSY_FETCH;
                     drop_next  = fetch_flush;
                  end
               end
            end
         end
         BUSY_FETCH: begin
            if (fetch_flush) drop_next = 1'b1;
            if (mem_valid) begin
               state_next = IDLE;
               drop_next  = 1'b0;
            end
         end
         BUSY_DATA: begin
            if (mem_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A flush arriving in the same cycle as the response still drops it.
   assign deliver_fetch = (state == BUSY_FETCH) && mem_valid && !(drop_q || fetch_flush);
   assign deliver_data  = (state == BUSY_DATA) && mem_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         drop_q            <= 1'b0;
         address_q         <= '0;
         fetch_valid       <= 1'b0;
         fetch_data        <= '0;
         fetch_address_out <= '0;
         data_valid        <= 1'b0;
         data_out          <= '0;
         data_address_out  <= '0;
      end else begin
         state       <= state_next;
         drop_q      <= drop_next;
         fetch_valid <= deliver_fetch;
         data_valid  <= deliver_data;
         if ((state == IDLE) && (state_next != IDLE)) begin
            address_q <= mem_address;
         end
         if (deliver_fetch) begin
            fetch_data        <= mem_rdata;
            fetch_address_out <= address_q;
         end
         if (deliver_data) begin
            data_out         <= mem_rdata;
            data_address_out <= address_q;
         end
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter against a memory model with
// mem_ready tied high and a two-cycle read latency.
module tb_memory_port_arbiter;

   localparam int AW = 20;
   localparam int DW = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic          fetch_read, fetch_flush, data_read, data_write, mem_ready, stray;
   logic [AW-1:0] fetch_address, data_address;
   logic [DW-1:0] data_in, mem_word;
   logic          fetch_ready, fetch_valid, data_ready, data_valid;
   logic [DW-1:0] fetch_data, data_out, mem_wdata;
   logic [AW-1:0] fetch_address_out, data_address_out, mem_address;
   logic          mem_read, mem_write, mem_valid;
   logic [1:0]    pipe = 2'b00;

   // Memory model: a read accepted in cycle 0 returns mem_valid in cycle 2.
   // It is not reset, so a response in flight at reset still arrives.
   always @(posedge clock) pipe <= {pipe[0], mem_read & mem_ready};
   assign mem_valid = pipe[1] | stray;

   memory_port_arbiter #(.ADDRESS_BITS(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .fetch_read(fetch_read), .fetch_address(fetch_address), .fetch_flush(fetch_flush),
      .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .fetch_address_out(fetch_address_out),
      .data_read(data_read), .data_write(data_write), .data_address(data_address),
      .data_in(data_in), .data_ready(data_ready), .data_valid(data_valid),
      .data_out(data_out), .data_address_out(data_address_out),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_valid(mem_valid),
      .mem_rdata(mem_word)
   );

   // Second instance with STARVE_LIMIT = 0: fetch must always win.
   logic          z_fetch_read, z_data_read;
   logic          z_fetch_ready, z_fetch_valid, z_data_ready, z_data_valid;
   logic [DW-1:0] z_fetch_data, z_data_out, z_mem_wdata;
   logic [AW-1:0] z_fetch_address_out, z_data_address_out, z_mem_address;
   logic          z_mem_read, z_mem_write, z_mem_valid;
   logic [1:0]    z_pipe = 2'b00;
   logic          z_zero = 1'b0;
   logic [AW-1:0] z_faddr = 20'h00010;
   logic [AW-1:0] z_daddr = 20'h00020;
   logic [DW-1:0] z_din = '0;

   always @(posedge clock) z_pipe <= {z_pipe[0], z_mem_read & mem_ready};
   assign z_mem_valid = z_pipe[1];

   memory_port_arbiter #(.ADDRESS_BITS(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut_zero (
      .clock(clock), .reset(reset),
      .fetch_read(z_fetch_read), .fetch_address(z_faddr), .fetch_flush(z_zero),
      .fetch_ready(z_fetch_ready), .fetch_valid(z_fetch_valid), .fetch_data(z_fetch_data),
      .fetch_address_out(z_fetch_address_out),
      .data_read(z_data_read), .data_write(z_zero), .data_address(z_daddr),
      .data_in(z_din), .data_ready(z_data_ready), .data_valid(z_data_valid),
      .data_out(z_data_out), .data_address_out(z_data_address_out),
      .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_address(z_mem_address),
      .mem_wdata(z_mem_wdata), .mem_ready(mem_ready), .mem_valid(z_mem_valid),
      .mem_rdata(mem_word)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] exp_order;
      int grants;
      int z_fetch_acc;
      int z_data_acc;

      fetch_read = 1'b1; fetch_flush = 1'b0; data_read = 1'b0; data_write = 1'b0;
      mem_ready = 1'b1; stray = 1'b0; fetch_address = 20'h00040; data_address = '0;
      data_in = '0; mem_word = '0; z_fetch_read = 1'b0; z_data_read = 1'b0;

      // Reset state: requests present but everything forced low.
      @(negedge clock); #1;
      check("rst_fetch_ready", fetch_ready, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_fetch_valid", fetch_valid, 0);
      check("rst_data_out", data_out, 0);
      fetch_read = 1'b0;
      reset = 1'b1;

      // Lone fetch: accept at cycle 0, response at cycle 3.
      @(negedge clock);
      fetch_read = 1'b1; fetch_address = 20'h00040; mem_word = 32'hDEADBEEF; #1;
      check("lf_fetch_ready", fetch_ready, 1);
      check("lf_mem_read", mem_read, 1);
      check("lf_mem_address", mem_address, 32'h40);
      check("lf_data_ready", data_ready, 0);
      @(negedge clock); fetch_read = 1'b0; #1;
      check("lf_busy_mem_read", mem_read, 0);
      @(negedge clock); #1;
      check("lf_c2_fetch_valid", fetch_valid, 0);
      @(negedge clock); #1;
      check("lf_fetch_valid", fetch_valid, 1);
      check("lf_fetch_data", fetch_data, 32'hDEADBEEF);
      check("lf_fetch_addr", fetch_address_out, 32'h40);
      check("lf_data_valid", data_valid, 0);
      @(negedge clock); #1;
      check("lf_pulse_end", fetch_valid, 0);
      check("lf_data_hold", fetch_data, 32'hDEADBEEF);

      // Store: completes on acceptance, back-to-back stores accepted.
      data_write = 1'b1; data_address = 20'h00100; data_in = 32'h5; #1;
      check("st_mem_write", mem_write, 1);
      check("st_mem_read", mem_read, 0);
      check("st_mem_wdata", mem_wdata, 32'h5);
      check("st_mem_address", mem_address, 32'h100);
      check("st_data_ready", data_ready, 1);
      @(negedge clock); data_address = 20'h00104; data_in = 32'h6; #1;
      check("st2_data_ready", data_ready, 1);
      check("st2_mem_wdata", mem_wdata, 32'h6);
      @(negedge clock); data_write = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 check("st_no_data_valid", data_valid, 0);
         @(negedge clock);
      end

      // Starvation bound: D x4, F, D x4, F.
      fetch_read = 1'b1; data_read = 1'b1;
      fetch_address = 20'h00080; data_address = 20'h00200; mem_word = 32'hCAFE0000;
      exp_order = 10'b10000_10000;
      grants = 0;
      for (int c = 0; c < 100 && grants < 10; c++) begin
         #1;
         if (fetch_ready || data_ready) begin
            check($sformatf("starve_grant%0d", grants), fetch_ready, exp_order[grants]);
            grants++;
         end
         if (grants < 10) @(negedge clock);
      end
      check("starve_grants", grants, 10);
      @(negedge clock); fetch_read = 1'b0; data_read = 1'b0;
      @(negedge clock);
      @(negedge clock); #1;
      check("starve_fetch_valid", fetch_valid, 1);
      check("starve_fetch_addr", fetch_address_out, 32'h80);
      check("starve_data_addr", data_address_out, 32'h200);
      check("starve_data_out", data_out, 32'hCAFE0000);

      // Flush: response dropped, IDLE at cycle 3, next fetch normal.
      @(negedge clock);
      fetch_read = 1'b1; fetch_address = 20'h00044; mem_word = 32'h11111111; #1;
      check("fl_fetch_ready", fetch_ready, 1);
      @(negedge clock); fetch_read = 1'b0; fetch_flush = 1'b1;
      @(negedge clock); fetch_flush = 1'b0;
      @(negedge clock);
      fetch_read = 1'b1; fetch_address = 20'h00048; mem_word = 32'h22222222; #1;
      check("fl_no_fetch_valid", fetch_valid, 0);
      check("fl_data_hold", fetch_data, 32'hCAFE0000);
      check("fl_idle_ready", fetch_ready, 1);
      @(negedge clock); fetch_read = 1'b0;
      @(negedge clock);
      @(negedge clock); #1;
      check("fl_next_valid", fetch_valid, 1);
      check("fl_next_data", fetch_data, 32'h22222222);
      check("fl_next_addr", fetch_address_out, 32'h48);

      // Reset in cycle 1 of a data read; stale and stray responses ignored.
      @(negedge clock);
      data_read = 1'b1; data_address = 20'h00300; mem_word = 32'h33333333; #1;
      check("rr_data_ready", data_ready, 1);
      @(negedge clock); fetch_read = 1'b1; reset = 1'b0; #1;
      check("rr_rst_data_ready", data_ready, 0);
      check("rr_rst_fetch_ready", fetch_ready, 0);
      check("rr_rst_mem_read", mem_read, 0);
      check("rr_rst_data_valid", data_valid, 0);
      check("rr_rst_fetch_data", fetch_data, 0);
      @(negedge clock); fetch_read = 1'b0; data_read = 1'b0; reset = 1'b1;
      @(negedge clock); stray = 1'b1; #1;
      check("rr_stale_data_valid", data_valid, 0);
      check("rr_stale_data_out", data_out, 0);
      @(negedge clock); stray = 1'b0; #1;
      check("rr_stray_data_valid", data_valid, 0);
      check("rr_stray_fetch_valid", fetch_valid, 0);
      data_read = 1'b1; data_address = 20'h00304; mem_word = 32'h44444444; #1;
      check("rr_new_ready", data_ready, 1);
      @(negedge clock); data_read = 1'b0;
      @(negedge clock);
      @(negedge clock); #1;
      check("rr_new_valid", data_valid, 1);
      check("rr_new_data", data_out, 32'h44444444);
      check("rr_new_addr", data_address_out, 32'h304);

      // Write wins over a simultaneous read.
      @(negedge clock);
      data_read = 1'b1; data_write = 1'b1; data_address = 20'h00108; data_in = 32'h9; #1;
      check("ww_mem_write", mem_write, 1);
      check("ww_mem_read", mem_read, 0);
      check("ww_data_ready", data_ready, 1);
      @(negedge clock); data_read = 1'b0; data_write = 1'b0;
      @(negedge clock); #1;
      check("ww_no_data_valid", data_valid, 0);

      // STARVE_LIMIT = 0: fetch always wins, accepted at cycles 0, 3, 6, 9.
      @(negedge clock);
      z_fetch_read = 1'b1; z_data_read = 1'b1;
      z_fetch_acc = 0; z_data_acc = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (z_fetch_ready) z_fetch_acc++;
         if (z_data_ready) z_data_acc++;
         @(negedge clock);
      end
      z_fetch_read = 1'b0; z_data_read = 1'b0;
      check("zero_fetch_grants", z_fetch_acc, 4);
      check("zero_data_grants", z_data_acc, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
